lora_tx_sequencer: RTL and testbench

- Frame-level symbol sequencer placed directly downstream of the startup wait counter.
- Stays idle until the counter's `countDone` is high, then accepts a transmit request.
- Emits one LoRa frame as a stream of (symbol value, chirp type) words to the chirp generator: preamble upchirps, two sync-word symbols, 2.25 downchirps, then payload symbols pulled from an upstream source.
- Both stream sides use valid/ready handshakes.

---
 rtl/lora_tx_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_lora_tx_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lora_tx_sequencer.sv
// ============================================================================
// Module   : lora_tx_sequencer
// Brief    : Emits one LoRa frame (preamble, sync, 2.25 downchirps, payload)
//            as a valid/ready stream of (symbol, chirp type) words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lora_tx_sequencer #(
    parameter int          SF           = 7,
    parameter int          PREAMBLE_LEN = 8,
    parameter logic [7:0]  SYNC_WORD    = 8'h34
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          countDone,
    input  logic          txStart,
    input  logic [7:0]    payloadLen,
    input  logic [SF-1:0] dataIn,
    input  logic          dataValid,
    output logic          dataReady,
    output logic [SF-1:0] symOut,
    output logic [1:0]    symType,
    output logic          symValid,
    input  logic          symReady,
    output logic          txBusy,
    output logic          txDone,
    output logic          txErr
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SYNC0, S_SYNC1, S_DOWN, S_QUARTER, S_PAYLOAD, S_FINISH
    } state_t;

    localparam logic [1:0]    c_UP       = 2'd0;
    localparam logic [1:0]    c_DOWN     = 2'd1;
    localparam logic [1:0]    c_QUARTER  = 2'd2;
    localparam logic [SF-1:0] c_ZERO     = '0;
    localparam logic [SF-1:0] c_SYNC0    = SF'({SYNC_WORD[7:4], 3'b000});
    localparam logic [SF-1:0] c_SYNC1    = SF'({SYNC_WORD[3:0], 3'b000});
    localparam logic [15:0]   c_PRE_LAST = 16'(PREAMBLE_LEN - 1);

    state_t        r_state,    w_state;
    logic [15:0]   r_preCnt,   w_preCnt;
    logic [7:0]    r_remain,   w_remain;
    logic          r_downCnt,  w_downCnt;
    logic [SF-1:0] r_symOut,   w_symOut;
    logic [1:0]    r_symType,  w_symType;
    logic          r_symValid, w_symValid;
    logic          r_txBusy,   w_txBusy;
    logic          r_txDone,   w_txDone;
    logic          r_txErr,    w_txErr;

    logic w_xfer;
    logic w_dataReady;
    logic w_take;

    assign w_xfer = r_symValid & symReady;

    // Payload fetch also opens during the quarter downchirp so the first payload
    // symbol lands on the same edge the quarter chirp leaves: no bubble.
    assign w_dataReady = ((r_state == S_PAYLOAD) || (r_state == S_QUARTER)) &&
                         (r_remain != 8'd0) && (!r_symValid || symReady);
    assign w_take      = dataValid & w_dataReady;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_preCnt   <= 16'd0;
            r_remain   <= 8'd0;
            r_downCnt  <= 1'b0;
            r_symOut   <= c_ZERO;
            r_symType  <= c_UP;
            r_symValid <= 1'b0;
            r_txBusy   <= 1'b0;
            r_txDone   <= 1'b0;
            r_txErr    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_preCnt   <= w_preCnt;
            r_remain   <= w_remain;
            r_downCnt  <= w_downCnt;
            r_symOut   <= w_symOut;
            r_symType  <= w_symType;
            r_symValid <= w_symValid;
            r_txBusy   <= w_txBusy;
            r_txDone   <= w_txDone;
            r_txErr    <= w_txErr;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_preCnt   = r_preCnt;
        w_remain   = r_remain;
        w_downCnt  = r_downCnt;
        w_symOut   = r_symOut;
        w_symType  = r_symType;
        w_symValid = r_symValid;
        w_txBusy   = r_txBusy;
        w_txDone   = 1'b0;
        w_txErr    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (txStart && countDone) begin
                    w_state    = S_PREAMBLE;
                    w_preCnt   = c_PRE_LAST;
                    w_remain   = payloadLen;
                    w_symOut   = c_ZERO;
                    w_symType  = c_UP;
                    w_symValid = 1'b1;
                    w_txBusy   = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (w_xfer) begin
                    if (r_preCnt == 16'd0) begin
                        w_state  = S_SYNC0;
                        w_symOut = c_SYNC0;
                    end else begin
                        w_preCnt = r_preCnt - 16'd1;
                    end
                end
            end
            S_SYNC0: begin
                if (w_xfer) begin
                    w_state  = S_SYNC1;
                    w_symOut = c_SYNC1;
                end
            end
            S_SYNC1: begin
                if (w_xfer) begin
                    w_state   = S_DOWN;
                    w_symOut  = c_ZERO;
                    w_symType = c_DOWN;
                    w_downCnt = 1'b1;
                end
            end
            S_DOWN: begin
                if (w_xfer) begin
                    if (r_downCnt) begin
                        w_downCnt = 1'b0;
                    end else begin
                        w_state   = S_QUARTER;
                        w_symType = c_QUARTER;
                    end
                end
            end
            S_QUARTER: begin
                if (w_xfer) begin
                    if (r_remain != 8'd0) begin
                        w_state = S_PAYLOAD;
                        if (w_take) begin
                            w_symOut   = dataIn;
                            w_symType  = c_UP;
                            w_remain   = r_remain - 8'd1;
                        end else begin
                            w_symValid = 1'b0;
                        end
                    end else begin
                        w_state    = S_FINISH;
                        w_symValid = 1'b0;
                        w_txDone   = 1'b1;
                        w_txBusy   = 1'b0;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_take) begin
                    w_symOut   = dataIn;
                    w_symType  = c_UP;
                    w_symValid = 1'b1;
                    w_remain   = r_remain - 8'd1;
                end else if (w_xfer) begin
                    w_symValid = 1'b0;
                    if (r_remain == 8'd0) begin
                        w_state  = S_FINISH;
                        w_txDone = 1'b1;
                        w_txBusy = 1'b0;
                    end
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Losing countDone mid-frame wins over everything, including a final transfer.
        if ((r_state != S_IDLE) && !countDone) begin
            w_state    = S_IDLE;
            w_symValid = 1'b0;
            w_txBusy   = 1'b0;
            w_txDone   = 1'b0;
            w_txErr    = 1'b1;
            w_remain   = 8'd0;
            w_preCnt   = 16'd0;
            w_downCnt  = 1'b0;
        end
    end

    assign dataReady = w_dataReady;
    assign symOut    = r_symOut;
    assign symType   = r_symType;
    assign symValid  = r_symValid;
    assign txBusy    = r_txBusy;
    assign txDone    = r_txDone;
    assign txErr     = r_txErr;

endmodule

`default_nettype wire

// File: tb/tb_lora_tx_sequencer.sv
// ============================================================================
// Module   : tb_lora_tx_sequencer
// Brief    : Directed self-checking bench for lora_tx_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lora_tx_sequencer;

    localparam int SF = 7;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          countDone = 1'b0;
    logic          txStart = 1'b0;
    logic [7:0]    payloadLen = 8'd0;
    logic [SF-1:0] dataIn = '0;
    logic          dataValid = 1'b0;
    logic          dataReady;
    logic [SF-1:0] symOut;
    logic [1:0]    symType;
    logic          symValid;
    logic          symReady = 1'b1;
    logic          txBusy;
    logic          txDone;
    logic          txErr;

    lora_tx_sequencer #(.SF(SF), .PREAMBLE_LEN(8), .SYNC_WORD(8'h34)) dut (
        .clk(clk), .rstn(rstn), .countDone(countDone), .txStart(txStart),
        .payloadLen(payloadLen), .dataIn(dataIn), .dataValid(dataValid),
        .dataReady(dataReady), .symOut(symOut), .symType(symType),
        .symValid(symValid), .symReady(symReady), .txBusy(txBusy),
        .txDone(txDone), .txErr(txErr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [SF-1:0]   src_q[$];
    logic [SF-1:0]   pay_q[$];
    logic [SF+1:0]   rx_q[$];
    logic [SF+1:0]   exp_q[$];
    bit              gap_mode = 0;
    bit              rdy_mode = 0;

    int cyc = 0, first_x = -1, last_x = -1, done_cyc = -1;
    int n_valid = 0, n_done = 0, n_err = 0, stall_bad = 0;
    bit ready_seen = 0, mon_take = 0, p_stall = 0;
    logic [SF-1:0] p_out;
    logic [1:0]    p_type;

    // Monitor: samples on the falling edge, midway between driving and capture.
    always @(negedge clk) begin
        cyc++;
        if (rstn && dataReady) ready_seen = 1;
        mon_take = rstn && dataValid && dataReady;
        if (rstn && countDone && symValid && symReady) begin
            rx_q.push_back({symType, symOut});
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        if (symValid) n_valid++;
        if (txDone) begin n_done++; done_cyc = cyc; end
        if (txErr) n_err++;
        if (p_stall && !(symValid && symOut == p_out && symType == p_type)) stall_bad++;
        p_stall = rstn && countDone && symValid && !symReady;
        p_out   = symOut;
        p_type  = symType;
    end

    // Upstream source and downstream ready pattern.
    always @(posedge clk) begin
        #1;
        if (mon_take && src_q.size() > 0) void'(src_q.pop_front());
        dataValid = (src_q.size() > 0) && (!gap_mode || (cyc % 3 != 1));
        dataIn    = (src_q.size() > 0) ? src_q[0] : '0;
        symReady  = !rdy_mode || (cyc % 4 == 0) || (cyc % 4 == 3);
    end

    task automatic clear_mon();
        rx_q.delete();
        first_x = -1; last_x = -1; done_cyc = -1;
        n_valid = 0; ready_seen = 0; stall_bad = 0;
    endtask

    task automatic start_frame(input int len);
        payloadLen = 8'(len);
        txStart = 1'b1;
        @(posedge clk); #1;
        txStart = 1'b0;
    endtask

    task automatic load_payload(input int len, input int base, input int step);
        src_q.delete(); pay_q.delete();
        for (int i = 0; i < len; i++) begin
            src_q.push_back(SF'(base + i * step));
            pay_q.push_back(SF'(base + i * step));
        end
    endtask

    // Hand-derived frame for SYNC_WORD 0x34: sync symbols 3<<3=24 and 4<<3=32.
    task automatic build_exp(input int len);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({2'd0, 7'd0});
        exp_q.push_back({2'd0, 7'd24});
        exp_q.push_back({2'd0, 7'd32});
        exp_q.push_back({2'd1, 7'd0});
        exp_q.push_back({2'd1, 7'd0});
        exp_q.push_back({2'd2, 7'd0});
        for (int i = 0; i < len; i++) exp_q.push_back({2'd0, pay_q[i]});
    endtask

    function automatic int first_diff();
        int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
        if (rx_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic wait_end(input int budget, output bit seen_done);
        seen_done = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (txDone === 1'b1) begin seen_done = 1; break; end
            if (txErr === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({symOut, symType, symValid} !== '0) begin
            errors++; $display("FAIL reset_sym got=%h exp=0", {symOut, symType, symValid});
        end
        checks++;
        if (dataReady !== 1'b0) begin errors++; $display("FAIL reset_dataReady got=%b exp=0", dataReady); end
        checks++;
        if (txBusy !== 1'b0) begin errors++; $display("FAIL reset_txBusy got=%b exp=0", txBusy); end
        checks++;
        if ({txDone, txErr} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {txDone, txErr}); end
        rstn = 1'b1;
        countDone = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        bit ok;
        int d;
        load_payload(3, 5, 1);
        build_exp(3);
        clear_mon();
        start_frame(3);
        checks++;
        if ({txBusy, symValid, symOut, symType} !== {1'b1, 1'b1, 7'd0, 2'd0}) begin
            errors++; $display("FAIL basic_first got=%h exp=%h", {txBusy, symValid, symOut, symType}, {1'b1, 1'b1, 7'd0, 2'd0});
        end
        wait_end(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done got=0 exp=1"); end
        checks++;
        if (txBusy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", txBusy); end
        @(posedge clk); #1;
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL basic_seq diff_idx=%0d exp=-1 got_len=%0d exp_len=%0d", d, rx_q.size(), exp_q.size()); end
        checks++;
        if (last_x - first_x != 15) begin errors++; $display("FAIL basic_span got=%0d exp=15", last_x - first_x); end
        checks++;
        if (n_valid != 16) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=16", n_valid); end
        checks++;
        if (done_cyc - last_x != 1) begin errors++; $display("FAIL basic_done_latency got=%0d exp=1", done_cyc - last_x); end
    endtask

    task automatic test_countdone_gate();
        bit ok;
        load_payload(0, 0, 0);
        countDone = 1'b0;
        start_frame(0);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({txBusy, symValid} !== 2'b00) begin errors++; $display("FAIL gate_ignored got=%b exp=00", {txBusy, symValid}); end
        countDone = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (txBusy !== 1'b0) begin errors++; $display("FAIL gate_no_late_start got=%b exp=0", txBusy); end
        start_frame(0);
        checks++;
        if ({txBusy, symValid} !== 2'b11) begin errors++; $display("FAIL gate_start got=%b exp=11", {txBusy, symValid}); end
        wait_end(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gate_done got=0 exp=1"); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_payload();
        bit ok;
        int d;
        load_payload(0, 0, 0);
        build_exp(0);
        clear_mon();
        start_frame(0);
        wait_end(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_done got=0 exp=1"); end
        @(posedge clk); #1;
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL zero_seq diff_idx=%0d exp=-1 got_len=%0d exp_len=13", d, rx_q.size()); end
        checks++;
        if (ready_seen) begin errors++; $display("FAIL zero_dataReady got=1 exp=0"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int d;
        load_payload(5, 9, 1);
        build_exp(5);
        clear_mon();
        gap_mode = 1; rdy_mode = 1;
        start_frame(5);
        wait_end(400, ok);
        gap_mode = 0; rdy_mode = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done got=0 exp=1"); end
        @(posedge clk); #1;
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL bp_seq diff_idx=%0d exp=-1 got_len=%0d exp_len=%0d", d, rx_q.size(), exp_q.size()); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", stall_bad); end
    endtask

    task automatic test_abort();
        bit ok;
        int d, d0;
        load_payload(2, 1, 1);
        clear_mon();
        d0 = n_done;
        start_frame(2);
        for (int k = 0; k < 40; k++) begin
            if (symValid === 1'b1 && symOut === 7'd32) break;
            @(posedge clk); #1;
        end
        countDone = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({txErr, symValid, txBusy, dataReady} !== 4'b1000) begin
            errors++; $display("FAIL abort_state got=%b exp=1000", {txErr, symValid, txBusy, dataReady});
        end
        @(posedge clk); #1;
        checks++;
        if (txErr !== 1'b0) begin errors++; $display("FAIL abort_pulse_width got=%b exp=0", txErr); end
        checks++;
        if (n_done != d0) begin errors++; $display("FAIL abort_no_done got=%0d exp=%0d", n_done, d0); end
        checks++;
        if (rx_q.size() != 9) begin errors++; $display("FAIL abort_xfers got=%0d exp=9", rx_q.size()); end
        countDone = 1'b1;
        @(posedge clk); #1;
        load_payload(2, 1, 1);
        build_exp(2);
        clear_mon();
        start_frame(2);
        wait_end(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_restart_done got=0 exp=1"); end
        @(posedge clk); #1;
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL abort_restart_seq diff_idx=%0d exp=-1 got_len=%0d", d, rx_q.size()); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int d, d0, e0;
        load_payload(4, 3, 1);
        clear_mon();
        start_frame(4);
        for (int k = 0; k < 60; k++) begin
            if (symValid === 1'b1 && symType === 2'd0 && symOut === 7'd3) break;
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({symOut, symType, symValid, dataReady, txBusy, txDone, txErr} !== '0) begin
            errors++; $display("FAIL midreset_outputs got=%h exp=0", {symOut, symType, symValid, dataReady, txBusy, txDone, txErr});
        end
        rstn = 1'b1;
        src_q.delete();
        d0 = n_done; e0 = n_err;
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (n_done != d0 || n_err != e0) begin
            errors++; $display("FAIL midreset_pulses got=%0d/%0d exp=%0d/%0d", n_done, n_err, d0, e0);
        end
        load_payload(255, 1, 3);
        build_exp(255);
        clear_mon();
        start_frame(255);
        wait_end(1500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL long_done got=0 exp=1"); end
        @(posedge clk); #1;
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL long_seq diff_idx=%0d exp=-1 got_len=%0d exp_len=268", d, rx_q.size()); end
        checks++;
        if (n_err != e0) begin errors++; $display("FAIL long_no_err got=%0d exp=%0d", n_err, e0); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_countdone_gate();
        test_zero_payload();
        test_backpressure();
        test_abort();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
